// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | regfile_wb_arbiter: shares the register-file write port between load       |
// | returns (strict priority) and a FIFO-buffered ALU write-back stream.        |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module regfile_wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid_i,
  output logic                          alu_ready_o,
  input  logic [ADDRESS_WIDTH-1:0]      alu_rd_i,
  input  logic [DATA_WIDTH-1:0]         alu_data_i,
  input  logic                          ld_valid_i,
  input  logic [ADDRESS_WIDTH-1:0]      ld_rd_i,
  input  logic [DATA_WIDTH-1:0]         ld_data_i,
  output logic                          WE3_o,
  output logic [ADDRESS_WIDTH-1:0]      AD3_o,
  output logic [DATA_WIDTH-1:0]         WD3_o,
  output logic [2**ADDRESS_WIDTH-1:0]   pending_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int C_PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int C_CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int C_NREG = 2**ADDRESS_WIDTH;
  localparam logic [C_CW-1:0] C_DEPTH = C_CW'(FIFO_DEPTH);

  logic [ADDRESS_WIDTH-1:0] r_rd   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    r_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    r_vld;
  logic [C_PW-1:0]          r_head;
  logic [C_PW-1:0]          r_tail;
  logic [C_CW-1:0]          r_count;

  logic                     r_we;
  logic [ADDRESS_WIDTH-1:0] r_ad;
  logic [DATA_WIDTH-1:0]    r_wd;

  logic                     w_push;
  logic                     w_pop;
  logic                     w_ld_issue;
  logic [C_NREG-1:0]        w_pending;

  // Ready depends only on registered occupancy, never on the load path.
  assign alu_ready_o = (r_count < C_DEPTH);
  assign w_ld_issue  = ld_valid_i && (ld_rd_i != '0);
  assign w_push      = alu_valid_i && alu_ready_o && (alu_rd_i != '0);
  assign w_pop       = !w_ld_issue && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Pop first so a same-edge push into the freed slot is not overwritten.
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      if (w_push) begin
        r_rd[r_tail]   <= alu_rd_i;
        r_data[r_tail] <= alu_data_i;
        r_vld[r_tail]  <= 1'b1;
        r_tail         <= r_tail + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we <= 1'b0;
      r_ad <= '0;
      r_wd <= '0;
    end else if (w_ld_issue) begin
      r_we <= 1'b1;
      r_ad <= ld_rd_i;
      r_wd <= ld_data_i;
    end else if (w_pop) begin
      r_we <= 1'b1;
      r_ad <= r_rd[r_head];
      r_wd <= r_data[r_head];
    end else begin
      r_we <= 1'b0;
    end
  end

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_vld[i]) w_pending[r_rd[i]] = 1'b1;
    end
    if (r_we) w_pending[r_ad] = 1'b1;
    w_pending[0] = 1'b0;
  end

  assign WE3_o        = r_we;
  assign AD3_o        = r_ad;
  assign WD3_o        = r_wd;
  assign pending_o    = w_pending;
  assign fifo_count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// Directed self-checking bench for regfile_wb_arbiter (default parameters).
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid_i = 1'b0;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_i = '0;
  logic [31:0] alu_data_i = '0;
  logic        ld_valid_i = 1'b0;
  logic [4:0]  ld_rd_i = '0;
  logic [31:0] ld_data_i = '0;
  logic        WE3_o;
  logic [4:0]  AD3_o;
  logic [31:0] WD3_o;
  logic [31:0] pending_o;
  logic [1:0]  fifo_count_o;

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_wb_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .ld_valid_i(ld_valid_i), .ld_rd_i(ld_rd_i), .ld_data_i(ld_data_i),
    .WE3_o(WE3_o), .AD3_o(AD3_o), .WD3_o(WD3_o),
    .pending_o(pending_o), .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wport(input string tag, input logic we, input logic [4:0] ad, input logic [31:0] wd);
    chk({tag, ".we"}, 64'(WE3_o), 64'(we));
    chk({tag, ".ad"}, 64'(AD3_o), 64'(ad));
    chk({tag, ".wd"}, 64'(WD3_o), 64'(wd));
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid_i = v; alu_rd_i = rd; alu_data_i = d;
  endtask

  task automatic ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ld_valid_i = v; ld_rd_i = rd; ld_data_i = d;
  endtask

  initial begin
    // Reset held, then released between edges
    tick(); tick();
    chk("rst.we", 64'(WE3_o), 64'd0);
    chk("rst.pending", 64'(pending_o), 64'd0);
    chk("rst.ready", 64'(alu_ready_o), 64'd1);
    chk("rst.count", 64'(fifo_count_o), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    wport("rel", 1'b0, 5'd0, 32'd0);
    chk("rel.pending", 64'(pending_o), 64'd0);
    chk("rel.ready", 64'(alu_ready_o), 64'd1);
    chk("rel.count", 64'(fifo_count_o), 64'd0);

    // Single ALU write
    alu(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    alu(1'b0, 5'd0, 32'd0);
    chk("alu1.e0.we", 64'(WE3_o), 64'd0);
    chk("alu1.e0.count", 64'(fifo_count_o), 64'd1);
    chk("alu1.e0.pending", 64'(pending_o), 64'h20);
    tick();
    wport("alu1.e1", 1'b1, 5'd5, 32'hDEADBEEF);
    chk("alu1.e1.count", 64'(fifo_count_o), 64'd0);
    chk("alu1.e1.pending", 64'(pending_o), 64'h20);
    tick();
    wport("alu1.e2", 1'b0, 5'd5, 32'hDEADBEEF);
    chk("alu1.e2.pending", 64'(pending_o), 64'd0);

    // Load priority over queued ALU result
    alu(1'b1, 5'd3, 32'h11);
    tick();
    alu(1'b0, 5'd0, 32'd0);
    ld(1'b1, 5'd7, 32'h22);
    chk("pri.e0.pending", 64'(pending_o), 64'h08);
    tick();
    wport("pri.e1", 1'b1, 5'd7, 32'h22);
    chk("pri.e1.count", 64'(fifo_count_o), 64'd1);
    chk("pri.e1.pending", 64'(pending_o), 64'h88);
    tick();
    ld(1'b0, 5'd0, 32'd0);
    wport("pri.e2", 1'b1, 5'd7, 32'h22);
    chk("pri.e2.count", 64'(fifo_count_o), 64'd1);
    tick();
    wport("pri.e3", 1'b1, 5'd3, 32'h11);
    chk("pri.e3.count", 64'(fifo_count_o), 64'd0);
    chk("pri.e3.pending", 64'(pending_o), 64'h08);
    tick();
    chk("pri.e4.we", 64'(WE3_o), 64'd0);

    // Back-pressure under sustained loads
    ld(1'b1, 5'd1, 32'hAA);
    alu(1'b1, 5'd2, 32'h102);
    tick();
    alu(1'b1, 5'd3, 32'h103);
    chk("bp.e0.count", 64'(fifo_count_o), 64'd1);
    chk("bp.e0.ready", 64'(alu_ready_o), 64'd1);
    tick();
    alu(1'b1, 5'd4, 32'h104);
    chk("bp.e1.count", 64'(fifo_count_o), 64'd2);
    chk("bp.e1.ready", 64'(alu_ready_o), 64'd0);
    tick();
    ld(1'b0, 5'd0, 32'd0);
    wport("bp.e2", 1'b1, 5'd1, 32'hAA);
    chk("bp.e2.count", 64'(fifo_count_o), 64'd2);
    chk("bp.e2.ready", 64'(alu_ready_o), 64'd0);
    chk("bp.e2.pending", 64'(pending_o), 64'h0E);
    tick();
    wport("bp.e3", 1'b1, 5'd2, 32'h102);
    chk("bp.e3.count", 64'(fifo_count_o), 64'd1);
    chk("bp.e3.ready", 64'(alu_ready_o), 64'd1);
    tick();
    alu(1'b0, 5'd0, 32'd0);
    wport("bp.e4", 1'b1, 5'd3, 32'h103);
    chk("bp.e4.count", 64'(fifo_count_o), 64'd1);
    tick();
    wport("bp.e5", 1'b1, 5'd4, 32'h104);
    chk("bp.e5.count", 64'(fifo_count_o), 64'd0);
    tick();
    chk("bp.e6.we", 64'(WE3_o), 64'd0);

    // x0 handling on both sources with FIFO head rd 9
    alu(1'b1, 5'd9, 32'h99);
    ld(1'b1, 5'd1, 32'h55);
    tick();
    alu(1'b1, 5'd0, 32'h77);
    ld(1'b1, 5'd0, 32'h66);
    wport("x0.pre", 1'b1, 5'd1, 32'h55);
    chk("x0.pre.count", 64'(fifo_count_o), 64'd1);
    tick();
    alu(1'b0, 5'd0, 32'd0);
    ld(1'b0, 5'd0, 32'd0);
    wport("x0.e1", 1'b1, 5'd9, 32'h99);
    chk("x0.e1.count", 64'(fifo_count_o), 64'd0);
    chk("x0.e1.pending", 64'(pending_o), 64'h200);
    chk("x0.e1.p0", 64'(pending_o[0]), 64'd0);
    tick();
    chk("x0.e2.we", 64'(WE3_o), 64'd0);

    // Mid-operation asynchronous reset
    ld(1'b1, 5'd1, 32'hBB);
    alu(1'b1, 5'd10, 32'hA0);
    tick();
    alu(1'b1, 5'd11, 32'hB0);
    tick();
    chk("mr.pre.count", 64'(fifo_count_o), 64'd2);
    chk("mr.pre.pending", 64'(pending_o), 64'h0C02);
    #2;
    rst_n = 1'b0;
    alu(1'b0, 5'd0, 32'd0);
    ld(1'b0, 5'd0, 32'd0);
    #1;
    wport("mr.in", 1'b0, 5'd0, 32'd0);
    chk("mr.in.pending", 64'(pending_o), 64'd0);
    chk("mr.in.count", 64'(fifo_count_o), 64'd0);
    chk("mr.in.ready", 64'(alu_ready_o), 64'd1);
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr.post.we", 64'(WE3_o), 64'd0);
      chk("mr.post.pending", 64'(pending_o), 64'd0);
    end

    // Back-to-back ALU throughput
    alu(1'b1, 5'd12, 32'hC12);
    tick();
    alu(1'b1, 5'd13, 32'hC13);
    tick();
    alu(1'b0, 5'd0, 32'd0);
    wport("tp.e1", 1'b1, 5'd12, 32'hC12);
    chk("tp.e1.count", 64'(fifo_count_o), 64'd1);
    tick();
    wport("tp.e2", 1'b1, 5'd13, 32'hC13);
    chk("tp.e2.count", 64'(fifo_count_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port (WE3/AD3/WD3) between two write-back requesters: the ALU result path and the load-return path from data memory. Load returns have strict priority because memory cannot be stalled. ALU results are buffered in a small FIFO and back-pressured with a ready signal. A per-register pending mask is exported to issue/hazard logic. Sits between the execute/memory stages and the register file.

## Interface
- ADDRESS_WIDTH, 5, register index width; 2**ADDRESS_WIDTH architectural registers
- DATA_WIDTH, 32, write data width
- FIFO_DEPTH, 2, ALU write-back FIFO entries; power of two, ≥2
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_valid_i  in  1  ALU result presented this cycle
- alu_ready_o  out  1  ALU result accepted at this edge when alu_valid_i is also high
- alu_rd_i  in  ADDRESS_WIDTH  ALU destination register
- alu_data_i  in  DATA_WIDTH  ALU result
- ld_valid_i  in  1  load data returning this cycle; always accepted
- ld_rd_i  in  ADDRESS_WIDTH  load destination register
- ld_data_i  in  DATA_WIDTH  load data
- WE3_o  out  1  register-file write enable; registered
- AD3_o  out  ADDRESS_WIDTH  register-file write address; registered
- WD3_o  out  DATA_WIDTH  register-file write data; registered
- pending_o  out  2**ADDRESS_WIDTH  bit r set while a write to r is queued or on the write port
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current ALU FIFO occupancy

## Operation
- ALU push: on a rising edge with alu_valid_i && alu_ready_o and alu_rd_i != 0, the {rd, data} pair enters the FIFO tail. When alu_rd_i == 0, the handshake completes but nothing is enqueued.
- alu_ready_o = (fifo_count < FIFO_DEPTH). It is driven from registered count only, with no combinational path from ld_valid_i.
- Issue select, evaluated each cycle:
  - If ld_valid_i && ld_rd_i != 0, issue the load.
  - Otherwise, if the FIFO is non-empty, pop the head and issue it.
  - Otherwise, issue nothing.
- A load to x0 is discarded. In that cycle the FIFO head may issue instead.
- The issued write is registered into WE3_o/AD3_o/WD3_o at the edge. When nothing issues, WE3_o = 0; AD3_o and WD3_o hold their previous values.
- Push and pop in the same edge: the count is unchanged, and head and tail pointers both advance. Pointers wrap modulo FIFO_DEPTH.
- The FIFO preserves ALU program order. No reordering is permitted between FIFO entries.
- Cross-source ordering (ALU vs load to the same rd) is not enforced here. Issue logic uses pending_o to avoid it.
- pending_o is combinational: the OR over valid FIFO entries of onehot(rd), plus onehot(AD3_o) when WE3_o = 1. Bit 0 is always 0.
- Reset (rst_n low, any time): FIFO emptied and pointers = 0. WE3_o = 0, AD3_o = 0, WD3_o = 0, pending_o = 0, fifo_count_o = 0, alu_ready_o = 1 while in reset. Any in-flight writes are lost.

## Timing
- Load path latency: ld_valid_i sampled at edge k gives WE3_o = 1 after edge k. The register file captures the data at edge k+1.
- ALU path latency, best case: pushed at edge k, issued at edge k+1, written to the register file at edge k+2.
- Starvation: while ld_valid_i stays high with nonzero rd every cycle, the FIFO does not drain. alu_ready_o falls once the FIFO fills and recovers the cycle after the first pop.
- Throughput: at most one register write per cycle. Sustained ALU throughput is 1/cycle with no loads.
- pending_o bit r clears after the edge at which the last queued write to r leaves the write-port register.

## Test plan
- Reset release: hold rst_n = 0, then release -> WE3_o = 0, pending_o = 0, alu_ready_o = 1, fifo_count_o = 0.
- Single ALU write: alu rd = 5, data = 0xDEADBEEF at edge 0 -> WE3_o = 1, AD3_o = 5, WD3_o = 0xDEADBEEF after edge 1. pending_o[5] is high from after edge 0 through edge 2.
- Load priority: ALU rd = 3 (data 0x11) pushed at edge 0; load rd = 7 (data 0x22) valid at edges 1–2 -> writes to 7 after edges 1 and 2; write to 3 after edge 3.
- Back-pressure: ld_valid_i held high to rd = 1, ALU pushes rd = 2, 3, 4 on consecutive cycles -> the first two are accepted; alu_ready_o = 0 while fifo_count_o = 2. After ld_valid_i drops: rd 2, 3, 4 issue in order.
- x0 handling: ALU rd = 0 and load rd = 0 in the same cycle with FIFO head rd = 9 -> no push; the head write to 9 issues; pending_o[0] stays 0.
- Mid-operation reset: FIFO holding 2 entries, assert rst_n low asynchronously between edges -> WE3_o = 0 and pending_o = 0 immediately. No stale writes after release.
